sync_pulse_sequencer: RTL

- Programmable multi-channel sequencer for the optical synchronizing pulse generator.
- Triggered by the debounced start strobe. Drives CH light-pulse outputs, each with its own configured delay and width.
- Locks out re-triggering until every channel has finished and a hold-off interval has elapsed. This enforces the "block until whole generation ends" rule system-wide.
- Sits between the start/debounce stage and the optical driver outputs; configured by the control host over a simple write port.

---
 rtl/sync_pulse_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sync_pulse_sequencer.sv
// Multi-channel light-pulse sequencer. A start rising edge fires every channel with its own delay and width.
// Re-triggering is locked out until the last channel ends and a hold-off interval has elapsed.
`timescale 1ns/1ps
module sync_pulse_sequencer #(
  parameter int unsigned CH      = 4,
  parameter int unsigned CW      = 32,
  parameter int unsigned HOLDOFF = 100000000
) (
  input  logic          sq_clk,
  input  logic          sq_rst_n,
  input  logic          sq_start,
  input  logic          sq_cfg_we,
  input  logic [6:0]    sq_cfg_addr,
  input  logic [CW-1:0] sq_cfg_data,
  output logic          sq_cfg_ack,
  output logic          sq_cfg_err,
  output logic [CH-1:0] sq_pulse,
  output logic          sq_busy,
  output logic          sq_done
);

  localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] dly   [CH];
  logic [CW-1:0] wid   [CH];
  logic [CW-1:0] dly_n [CH];
  logic [CW-1:0] wid_n [CH];
  logic [CW:0]   fin_q [CH];
  logic [CW:0]   fin_n [CH];
  logic [CW:0]   t_end, t_end_n;
  logic [CW:0]   cnt, cnt_n;
  logic [HW-1:0] hold, hold_n;
  logic [CH-1:0] pulse_n;
  logic          busy_n, done_n;
  logic          start_q, trigger, wr_ok;
  logic [31:0]   idx;

  assign idx     = {26'd0, sq_cfg_addr[6:1]};
  assign wr_ok   = sq_cfg_we && (state == IDLE) && (idx < CH);
  assign trigger = sq_start && !start_q && (state == IDLE);

  // Forwarded config view so a write landing on the trigger edge governs that sequence.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      dly_n[i] = dly[i];
      wid_n[i] = wid[i];
      if (wr_ok && idx == i) begin
        if (sq_cfg_addr[0]) wid_n[i] = sq_cfg_data;
        else                dly_n[i] = sq_cfg_data;
      end
    end
  end

  always_ff @(posedge sq_clk) begin
    if (!sq_rst_n) begin
      for (int unsigned i = 0; i < CH; i++) begin
        dly[i] <= '0;
        wid[i] <= '0;
      end
      sq_cfg_ack <= 1'b0;
      sq_cfg_err <= 1'b0;
    end else begin
      dly        <= dly_n;
      wid        <= wid_n;
      sq_cfg_ack <= wr_ok;
      sq_cfg_err <= sq_cfg_we && !wr_ok;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hold_n  = hold;
    t_end_n = t_end;
    fin_n   = fin_q;
    pulse_n = sq_pulse;
    busy_n  = sq_busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          t_end_n = '0;
          for (int unsigned i = 0; i < CH; i++) begin
            fin_n[i] = {1'b0, dly_n[i]} + {1'b0, wid_n[i]};
            if (fin_n[i] > t_end_n) t_end_n = fin_n[i];
          end
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        cnt_n = cnt + 1'b1;
        for (int unsigned i = 0; i < CH; i++)
          pulse_n[i] = (cnt >= {1'b0, dly[i]}) && (cnt < fin_q[i]);
        if (cnt == t_end) begin
          pulse_n = '0;
          hold_n  = HW'(HOLDOFF);
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (hold == '0) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          hold_n = hold - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sq_clk) begin
    if (!sq_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hold     <= '0;
      t_end    <= '0;
      for (int unsigned i = 0; i < CH; i++) fin_q[i] <= '0;
      sq_pulse <= '0;
      sq_busy  <= 1'b0;
      sq_done  <= 1'b0;
      start_q  <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hold     <= hold_n;
      t_end    <= t_end_n;
      fin_q    <= fin_n;
      sq_pulse <= pulse_n;
      sq_busy  <= busy_n;
      sq_done  <= done_n;
      start_q  <= sq_start;
    end
  end

endmodule
